// File: rtl/labs_energy.sv
// LABS sidelobe energy evaluator: adds one squared aperiodic autocorrelation
// term per cycle and stops early once the running sum exceeds a pruning bound.
module labs_energy #(
  parameter int SEQ_WIDTH = 16,
  parameter int E_WIDTH   = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SEQ_WIDTH-1:0] in_seq,
  input  logic [E_WIDTH-1:0]   in_bound,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEQ_WIDTH-1:0] out_seq,
  output logic [E_WIDTH-1:0]   out_energy,
  output logic                 out_pruned
);
  localparam int CW = $clog2(SEQ_WIDTH) + 1;
  localparam int KW = $clog2(SEQ_WIDTH) + 1;
  localparam int QW = 2 * CW;
  localparam int SW = ((E_WIDTH > QW) ? E_WIDTH : QW) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  logic [SEQ_WIDTH-1:0]  seq_q, seq_d;
  logic [E_WIDTH-1:0]    bound_q, bound_d;
  logic [E_WIDTH-1:0]    acc_q, acc_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  pruned_q, pruned_d;
  logic                  live_q;

  logic [SEQ_WIDTH-1:0]  diff;
  int                    pc;
  logic signed [CW-1:0]  ck;
  logic signed [QW-1:0]  ckx;
  logic [QW-1:0]         sq;
  logic [SW-1:0]         sum;
  logic [E_WIDTH-1:0]    acc_sat;

  // C_k = (N-k) - 2*(number of disagreeing pairs at lag k)
  always_comb begin
    diff = seq_q ^ (seq_q >> k_q);
    pc   = 0;
    for (int i = 0; i < SEQ_WIDTH; i++)
      if (i < SEQ_WIDTH - int'(k_q)) pc = pc + (diff[i] ? 1 : 0);
    ck      = CW'(SEQ_WIDTH - int'(k_q) - 2 * pc);
    ckx     = QW'(ck);
    sq      = QW'(ckx * ckx);
    sum     = SW'(acc_q) + SW'(sq);
    acc_sat = (sum > SW'({E_WIDTH{1'b1}})) ? {E_WIDTH{1'b1}} : sum[E_WIDTH-1:0];
  end

  assign in_ready   = (state_q == IDLE) && live_q;
  assign out_valid  = (state_q == DONE);
  assign out_seq    = seq_q;
  assign out_energy = acc_q;
  assign out_pruned = pruned_q;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    bound_d  = bound_q;
    acc_d    = acc_q;
    k_d      = k_q;
    pruned_d = pruned_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        seq_d    = in_seq;
        bound_d  = in_bound;
        acc_d    = '0;
        k_d      = KW'(1);
        pruned_d = 1'b0;
        state_d  = CALC;
      end
      CALC: begin
        acc_d = acc_sat;
        k_d   = k_q + KW'(1);
        // Pruning wins over normal completion when both hit on the last term.
        if (acc_sat > bound_q) begin
          pruned_d = 1'b1;
          state_d  = DONE;
        end else if (k_q == KW'(SEQ_WIDTH - 1)) begin
          state_d  = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      seq_q    <= '0;
      bound_q  <= '0;
      acc_q    <= '0;
      k_q      <= KW'(1);
      pruned_q <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seq_q    <= seq_d;
      bound_q  <= bound_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      pruned_q <= pruned_d;
      live_q   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_labs_energy.sv
// Bench for labs_energy: directed vector table, multi-cycle corner sequences
// and random candidates against a direct +1/-1 autocorrelation model.
module tb_labs_energy;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid10;
  logic        in_ready, in_ready10;
  logic [15:0] in_seq;
  logic [15:0] in_bound;
  logic [9:0]  in_bound10;
  logic        out_valid, out_valid10;
  logic        out_ready;
  logic [15:0] out_seq, out_seq10;
  logic [15:0] out_energy;
  logic [9:0]  out_energy10;
  logic        out_pruned, out_pruned10;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  labs_energy #(.SEQ_WIDTH(16), .E_WIDTH(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_seq(in_seq), .in_bound(in_bound),
    .out_valid(out_valid), .out_ready(out_ready), .out_seq(out_seq),
    .out_energy(out_energy), .out_pruned(out_pruned)
  );

  labs_energy #(.SEQ_WIDTH(16), .E_WIDTH(10)) dut10 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .in_valid(in_valid10), .in_ready(in_ready10), .in_seq(in_seq), .in_bound(in_bound10),
    .out_valid(out_valid10), .out_ready(1'b1), .out_seq(out_seq10),
    .out_energy(out_energy10), .out_pruned(out_pruned10)
  );

  typedef struct {
    logic [15:0] seq;
    logic [15:0] bound;
    int          e;
    int          p;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Energy from the +1/-1 definition, with saturation and pruning applied per term.
  function automatic void model(input logic [15:0] s, input int b, input int emax,
                                output int e, output int p, output int lat);
    int c;
    e = 0; p = 0; lat = 15;
    for (int k = 1; k < 16; k++) begin
      c = 0;
      for (int i = 0; i < 16 - k; i++) c += (s[i] == s[i+k]) ? 1 : -1;
      e += c * c;
      if (e > emax) e = emax;
      if (e > b) begin
        p = 1; lat = k;
        break;
      end
    end
  endfunction

  // Entered and left at a falling edge with the DUT idle.
  task automatic xact(input logic [15:0] s, input logic [15:0] b, input int ee, input int ep,
                      input int el, input int hold, input string nm);
    int j;
    chk({nm, "/in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1; in_seq = s; in_bound = b;
    @(negedge clk);
    in_valid = 1'b0; in_seq = 16'($urandom); in_bound = 16'($urandom);
    j = 0;
    while (!out_valid && j < 64) begin
      @(negedge clk);
      j++;
    end
    chk({nm, "/latency"}, 32'(j), el);
    chk({nm, "/energy"}, 32'(out_energy), ee);
    chk({nm, "/pruned"}, 32'(out_pruned), ep);
    chk({nm, "/seq"}, 32'(out_seq), 32'(s));
    for (int h = 0; h < hold; h++) begin
      in_valid = ~in_valid; in_seq = 16'($urandom);
      @(negedge clk);
      chk({nm, "/hold_valid"}, 32'(out_valid), 1);
      chk({nm, "/hold_ready"}, 32'(in_ready), 0);
      chk({nm, "/hold_energy"}, 32'(out_energy), ee);
      chk({nm, "/hold_seq"}, 32'(out_seq), 32'(s));
      chk({nm, "/hold_pruned"}, 32'(out_pruned), ep);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "/released"}, 32'(out_valid), 0);
    chk({nm, "/ready_again"}, 32'(in_ready), 1);
  endtask

  vec_t tbl[8];

  initial begin
    int e, p, lat, j, seen;
    logic [15:0] s, b;

    tbl[0] = '{16'h0000, 16'hFFFF, 1240, 0, 15};
    tbl[1] = '{16'h5555, 16'd1240, 1240, 0, 15};
    tbl[2] = '{16'h0000, 16'd300,   421, 1,  2};
    tbl[3] = '{16'hFFFF, 16'd0,     225, 1,  1};
    tbl[4] = '{16'h0000, 16'd225,   421, 1,  2};
    tbl[5] = '{16'h0000, 16'd1239, 1240, 1, 15};
    tbl[6] = '{16'hFFFF, 16'd1240, 1240, 0, 15};
    tbl[7] = '{16'hAAAA, 16'hFFFF, 1240, 0, 15};

    rst = 1'b1; in_valid = 1'b0; in_valid10 = 1'b0; out_ready = 1'b0;
    in_seq = '0; in_bound = '0; in_bound10 = '0;
    repeat (2) @(negedge clk);
    chk("rst/in_ready", 32'(in_ready), 0);
    chk("rst/out_valid", 32'(out_valid), 0);
    chk("rst/out_energy", 32'(out_energy), 0);
    chk("rst/out_seq", 32'(out_seq), 0);
    chk("rst/out_pruned", 32'(out_pruned), 0);
    chk("rst/in_ready10", 32'(in_ready10), 0);
    rst = 1'b0;
    #1 chk("rst/ready_before_edge", 32'(in_ready), 0);
    @(negedge clk);
    chk("rst/ready_after_edge", 32'(in_ready), 1);

    foreach (tbl[i])
      xact(tbl[i].seq, tbl[i].bound, tbl[i].e, tbl[i].p, tbl[i].lat, 0, $sformatf("tbl%0d", i));

    // Held result must ignore upstream activity; next accept takes the new candidate.
    xact(16'h0000, 16'd300, 421, 1, 2, 5, "hold");
    model(16'h00FF, 65535, 65535, e, p, lat);
    xact(16'h00FF, 16'hFFFF, e, p, lat, 0, "after_hold");

    // Reset in the middle of CALC.
    in_valid = 1'b1; in_seq = 16'h0000; in_bound = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("rcalc/out_valid", 32'(out_valid), 0);
    chk("rcalc/in_ready", 32'(in_ready), 0);
    chk("rcalc/out_energy", 32'(out_energy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rcalc/ready_after", 32'(in_ready), 1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("rcalc/no_result", 32'(seen), 0);
    xact(16'h0000, 16'hFFFF, 1240, 0, 15, 0, "rcalc_next");

    // Reset while a result is being held.
    in_valid = 1'b1; in_seq = 16'h0000; in_bound = 16'd300;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rdone/valid_before", 32'(out_valid), 1);
    #2 rst = 1'b1;
    #1 chk("rdone/out_valid", 32'(out_valid), 0);
    chk("rdone/out_pruned", 32'(out_pruned), 0);
    chk("rdone/out_energy", 32'(out_energy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rdone/ready_after", 32'(in_ready), 1);
    xact(16'h5555, 16'd1240, 1240, 0, 15, 0, "rdone_next");

    // Narrow accumulator saturates instead of wrapping.
    in_valid10 = 1'b1; in_seq = 16'h0000; in_bound10 = 10'h3FF;
    @(negedge clk);
    in_valid10 = 1'b0; in_seq = 16'($urandom);
    j = 0;
    while (!out_valid10 && j < 64) begin
      @(negedge clk);
      j++;
    end
    chk("sat/latency", 32'(j), 15);
    chk("sat/energy", 32'(out_energy10), 1023);
    chk("sat/pruned", 32'(out_pruned10), 0);
    @(negedge clk);

    for (int r = 0; r < 40; r++) begin
      s = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 1600));
      model(s, int'(b), 65535, e, p, lat);
      xact(s, b, e, p, lat, int'($urandom_range(0, 2)), $sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/labs_energy.md
LABS_ENERGY -- requirements
Module: labs_energy

Interface
REQ-001 SHALL have parameter SEQ_WIDTH, default 16: sequence length N, legal range 3..32.
REQ-002 SHALL have parameter E_WIDTH, default 16: width of the energy and bound values.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: a candidate sequence is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a candidate.
REQ-007 SHALL have port in_seq, input, SEQ_WIDTH bits: candidate; bit i=0 means s_i=+1, bit i=1 means s_i=-1.
REQ-008 SHALL have port in_bound, input, E_WIDTH bits: pruning threshold.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream consumer (search/compare stage) takes the result.
REQ-011 SHALL have port out_seq, output, SEQ_WIDTH bits: the captured candidate.
REQ-012 SHALL have port out_energy, output, E_WIDTH bits: accumulated energy.
REQ-013 SHALL have port out_pruned, output, 1 bit: computation stopped early because the bound was exceeded.

Function
REQ-014 SHALL compute E = sum over k=1..N-1 of C_k^2, where C_k = sum over i=0..N-1-k of s_i*s_{i+k}.
REQ-015 SHALL evaluate C_k as (N-k) - 2*popcount((seq ^ (seq>>k)) masked to its low N-k bits), as a signed value of ceil(log2 N)+1 bits.
REQ-016 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-017 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 In IDLE, when in_valid=1: SHALL capture in_seq and in_bound, clear the accumulator, set k=1, and enter CALC.
REQ-019 In CALC: SHALL add exactly one C_k^2 per cycle, in order k=1,2,..., then increment k.
REQ-020 SHALL saturate the accumulator at 2^E_WIDTH-1 and never wrap.
REQ-021 SHALL leave CALC for DONE in the cycle the updated accumulator is strictly greater than the captured bound, with out_pruned=1.
REQ-022 SHALL leave CALC for DONE after the k=N-1 term, with out_pruned=0, if the bound was never exceeded.
REQ-023 If both REQ-021 and REQ-022 apply in the same cycle, SHALL report out_pruned=1.
REQ-024 Unpruned latency: out_valid SHALL rise exactly N-1 cycles after the accepting edge (15 for N=16).
REQ-025 Pruned after term k: out_valid SHALL rise k cycles after the accepting edge.
REQ-026 In DONE: out_seq, out_energy and out_pruned SHALL stay stable until out_valid and out_ready are both high.
REQ-027 After that handshake, the block SHALL return to IDLE, and in_ready SHALL be 1 on the following cycle.
REQ-028 in_valid SHALL be ignored outside IDLE; in_seq and in_bound changes after capture SHALL have no effect.

Reset
REQ-029 While wb_rst_i=1, SHALL immediately force: state=IDLE, in_ready=0, out_valid=0, out_pruned=0, out_energy=0, out_seq=0, k=1.
REQ-030 SHALL drive in_ready=1 from the first rising edge after reset deasserts.
REQ-031 Reset mid-CALC or mid-DONE SHALL discard the operation; no result is emitted afterwards.

Verification
REQ-032 N=16, in_seq=0x0000, in_bound=0xFFFF -> out_valid 15 cycles after accept, out_energy=1240, out_pruned=0.
REQ-033 in_seq=0x5555, in_bound=1240 -> out_energy=1240, out_pruned=0 (equality does not prune).
REQ-034 in_seq=0x0000, in_bound=300 -> out_valid 2 cycles after accept, out_energy=421 (225+196), out_pruned=1.
REQ-035 E_WIDTH=10, in_seq=0x0000, in_bound=1023 -> out_energy=1023 (saturated), out_pruned=0, latency 15.
REQ-036 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_seq -> outputs stable, in_ready=0; first accept after the handshake uses the new in_seq.
REQ-037 Assert wb_rst_i asynchronously at CALC cycle 7 -> out_valid=0 at once, in_ready=1 after release, and the next candidate gives the correct E.
